axi_dma_wr_drain: RTL and testbench
===================================

Name: axi_dma_wr_drain

Overview:
- Read-side consumer of the DMA sync FIFO: pops buffered beats and writes them to memory as AXI4 INCR write bursts (AW/W/B), one burst outstanding at a time.
- Sits between the sync FIFO output and the AXI interconnect master write port.
- A transfer is started by the DMA control logic (start/addr/len) and reports done/err.

Parameters:
DATA_WIDTH, 128, FIFO and AXI W data width (bits); power of 2, 32..1024
ADDR_WIDTH, 32, AXI address width
FIFO_PTR, 16, width of FIFO occupancy count input
LEN_WIDTH, 24, transfer length field width, in beats
MAX_BURST, 16, max beats per AXI burst (1..256)

Ports:
clk  in  1  clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle transfer request, sampled only in IDLE
start_addr  in  ADDR_WIDTH  byte address, aligned to DATA_WIDTH/8
start_len  in  LEN_WIDTH  transfer length in beats
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at transfer end
err  out  1  set with done when any BRESP != OKAY; cleared by next accepted start
fifo_rd_en  out  1  FIFO pop request
fifo_rd_data  in  DATA_WIDTH  FIFO data, valid the cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty
fifo_data_avail_cnt  in  FIFO_PTR  FIFO occupancy
m_axi_awaddr  out  ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  DATA_WIDTH
m_axi_wstrb  out  DATA_WIDTH/8  all ones
m_axi_wlast  out  1
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1

Behaviour:
- Reset: all registered state cleared asynchronously. busy, done, err, fifo_rd_en, awvalid, wvalid, wlast, bready = 0; awaddr and awlen = 0; skid buffer empty. Reset mid-burst abandons the transfer; no completion is reported.
- FSM: IDLE, CALC, AW, W, B, DONE.
- IDLE: start=1 latches cur_addr and remaining, clears err, sets busy, goes to CALC. start in any other state is ignored. start_len=0 goes straight to DONE with no AXI traffic.
- CALC: blen = min(remaining, MAX_BURST, beats left to the next 4KB boundary), where boundary beats = (4096 - cur_addr[11:0]) / (DATA_WIDTH/8).
  - Waits while fifo_data_avail_cnt < blen, so W never stalls on an empty FIFO.
  - Then loads awaddr=cur_addr, awlen=blen-1, asserts awvalid, goes to AW.
- AW: awvalid and payload held stable until awready; on handshake, awvalid drops and the FSM goes to W. Prefetch may start in AW.
- W path: 2-entry skid buffer absorbs the 1-cycle FIFO read latency.
  - fifo_rd_en = state in {AW,W} && fetched < blen && !fifo_empty && (buffer entries + reads in flight) < 2.
  - wvalid = buffer non-empty; wdata = buffer head.
  - wlast = 1 on beat index blen-1.
  - A beat is popped only on wvalid && wready.
  - Throughput: 1 beat/cycle with wready held high.
  - wdata/wlast are stable while wvalid && !wready.
- W to B: after the wlast handshake, assert bready.
- B: on bvalid, deassert bready.
  - err |= (bresp != 2'b00).
  - cur_addr += blen*(DATA_WIDTH/8); remaining -= blen.
  - Go to DONE if remaining==0 or bresp != OKAY (error aborts the remaining bursts); otherwise go to CALC.
- DONE: done=1 for one cycle, busy=0 the same cycle, then IDLE. A start in the cycle after DONE is accepted.
- Width rules:
  - remaining is LEN_WIDTH bits; blen needs 9 bits.
  - Address add is modulo 2^ADDR_WIDTH.
  - No burst crosses a 4KB boundary.
- Never asserts fifo_rd_en while fifo_empty=1. Never fetches more than blen beats per burst.

Test Plan:
- addr=0x1000, len=16, FIFO preloaded with 16 beats, ready signals always high -> one AW with awlen=15, awsize=4, awburst=1; 16 W beats in order with wlast on beat 16; done 1 cycle after the B handshake, err=0.
- addr=0x0, len=40, MAX_BURST=16 -> three bursts: awaddr 0x000/0x100/0x200 with awlen 15/15/7; 40 fifo_rd_en pulses total.
- addr=0x0FE0, len=4 (128-bit) -> bursts split at 4KB: awaddr 0x0FE0 awlen=1, then 0x1000 awlen=1.
- FIFO refilled slowly (avail_cnt 3 for 20 cycles, then 16), len=16 -> no AWVALID until avail>=16; wready toggling 1010... -> no lost or duplicated beats, buffer never overflows, no rd_en while empty.
- bresp=2'b10 on the first of 3 bursts -> done pulses with err=1, no second AW; the next start clears err.
- reset_n low during W beat 5 -> all outputs 0 immediately. After release, a fresh start len=2 completes normally. start_len=0 -> done with no AW.

Source files
------------

// File: rtl/axi_dma_wr_drain_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_wr_drain_if
// Description : AXI4 write-address, write-data and write-response channel
//               bundle used between the DMA write drain and the interconnect.
//               master : drives AW/W payload and valids and BREADY
//               slave  : drives AWREADY, WREADY, BRESP and BVALID
// Revision    : 1.0  initial release
// ============================================================================
interface axi_dma_wr_drain_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  modport master (
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_dma_wr_drain.sv
`default_nettype none
// ============================================================================
// Module      : axi_dma_wr_drain
// Description : Pops beats from the DMA sync FIFO and writes them to memory
//               as AXI4 INCR bursts, one burst outstanding at a time.
//               Bursts are capped at MAX_BURST beats and never cross 4KB.
// Ports       : clk, reset_n             clock / async active-low reset
//               start, start_addr,
//               start_len                 transfer request (beats)
//               busy, done, err           transfer status
//               fifo_rd_en, fifo_rd_data,
//               fifo_empty,
//               fifo_data_avail_cnt       FIFO read side (1-cycle latency)
//               axi                       AXI4 AW/W/B master channels
// Revision    : 1.0  initial release
// ============================================================================
module axi_dma_wr_drain #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_PTR   = 16,
  parameter int LEN_WIDTH  = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR-1:0]   fifo_data_avail_cnt,
  axi_dma_wr_drain_if.master    axi
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_AW   = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [8:0]            r_blen;
  logic [8:0]            r_fetched;
  logic [8:0]            r_wcnt;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_rd_pending;

  // Two-entry skid buffer holding beats between the FIFO and the W channel.
  logic [DATA_WIDTH-1:0] r_buf [0:1];
  logic                  r_buf_wr_ptr;
  logic                  r_buf_rd_ptr;
  logic [1:0]            r_buf_cnt;

  logic [12:0] w_bnd_bytes;
  logic [12:0] w_bnd_beats;
  logic [8:0]  w_cap;
  logic [8:0]  w_blen;
  logic        w_fifo_ready;
  logic        w_wvalid;
  logic        w_pop;
  logic        w_wlast;
  logic        w_rd_en;

  // Burst length: min(remaining, MAX_BURST, beats to next 4KB boundary).
  assign w_bnd_bytes  = 13'd4096 - {1'b0, r_cur_addr[11:0]};
  assign w_bnd_beats  = w_bnd_bytes >> SIZE_LOG2;
  assign w_cap        = (w_bnd_beats < 13'(MAX_BURST)) ? w_bnd_beats[8:0] : 9'(MAX_BURST);
  assign w_blen       = (r_remaining < LEN_WIDTH'(w_cap)) ? r_remaining[8:0] : w_cap;
  // The whole burst must already sit in the FIFO so W never starves mid-burst.
  assign w_fifo_ready = 32'(fifo_data_avail_cnt) >= 32'(w_blen);

  // W is only presented once the address phase is done; beats fetched during
  // AW wait in the skid buffer.
  assign w_wvalid = (r_state == S_W) && (r_buf_cnt != 2'd0);
  assign w_pop    = w_wvalid && axi.m_axi_wready;
  assign w_wlast  = w_wvalid && (r_wcnt == (r_blen - 9'd1));

  // Occupancy plus in-flight reads must stay within two entries. A pop in the
  // same cycle frees a slot, which is what sustains one beat per cycle.
  assign w_rd_en = ((r_state == S_AW) || (r_state == S_W)) &&
                   (r_fetched < r_blen) && !fifo_empty &&
                   ((({1'b0, r_buf_cnt} + {2'b00, r_rd_pending}) < 3'd2) || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_blen       <= '0;
      r_fetched    <= '0;
      r_wcnt       <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rd_pending <= 1'b0;
      r_buf_wr_ptr <= 1'b0;
      r_buf_rd_ptr <= 1'b0;
      r_buf_cnt    <= 2'd0;
    end else begin
      r_done       <= 1'b0;
      r_rd_pending <= w_rd_en;
      if (w_rd_en) r_fetched <= r_fetched + 9'd1;
      if (w_pop)   r_wcnt    <= r_wcnt + 9'd1;

      if (r_rd_pending) r_buf_wr_ptr <= ~r_buf_wr_ptr;
      if (w_pop)        r_buf_rd_ptr <= ~r_buf_rd_ptr;
      case ({r_rd_pending, w_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur_addr  <= start_addr;
            r_remaining <= start_len;
            r_err       <= 1'b0;
            if (start_len == '0) begin
              // Empty transfer: report completion with no bus traffic.
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_fetched <= '0;
          r_wcnt    <= '0;
          if (w_fifo_ready) begin
            r_blen    <= w_blen;
            r_awaddr  <= r_cur_addr;
            r_awlen   <= 8'(w_blen - 9'd1);
            r_awvalid <= 1'b1;
            r_state   <= S_AW;
          end
        end
        S_AW: begin
          if (axi.m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_pop && w_wlast) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (axi.m_axi_bvalid) begin
            r_bready    <= 1'b0;
            if (axi.m_axi_bresp != 2'b00) r_err <= 1'b1;
            r_cur_addr  <= r_cur_addr + (ADDR_WIDTH'(r_blen) << SIZE_LOG2);
            r_remaining <= r_remaining - LEN_WIDTH'(r_blen);
            // An error response abandons whatever is left of the transfer.
            if ((r_remaining == LEN_WIDTH'(r_blen)) || (axi.m_axi_bresp != 2'b00)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer payload needs no reset; validity is tracked by r_buf_cnt.
  always_ff @(posedge clk) begin
    if (r_rd_pending) r_buf[r_buf_wr_ptr] <= fifo_rd_data;
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign fifo_rd_en = w_rd_en;

  assign axi.m_axi_awaddr  = r_awaddr;
  assign axi.m_axi_awlen   = r_awlen;
  assign axi.m_axi_awsize  = 3'(SIZE_LOG2);
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awvalid = r_awvalid;
  assign axi.m_axi_wdata   = r_buf[r_buf_rd_ptr];
  assign axi.m_axi_wstrb   = '1;
  assign axi.m_axi_wlast   = w_wlast;
  assign axi.m_axi_wvalid  = w_wvalid;
  assign axi.m_axi_bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_wr_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_dma_wr_drain
// Description : Self-checking bench for axi_dma_wr_drain. Models the FIFO and
//               an AXI write slave, logs AW/W traffic and compares it against
//               a burst-splitting reference computed from address and length.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_dma_wr_drain;
  localparam int DATA_WIDTH = 128;
  localparam int ADDR_WIDTH = 32;
  localparam int FIFO_PTR   = 16;
  localparam int LEN_WIDTH  = 24;
  localparam int MAX_BURST  = 16;
  localparam int BYTES      = DATA_WIDTH / 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  start_len;
  logic                  busy, done, err, fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [FIFO_PTR-1:0]   fifo_data_avail_cnt;

  axi_dma_wr_drain_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) axi ();

  axi_dma_wr_drain #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_PTR(FIFO_PTR),
    .LEN_WIDTH(LEN_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .start(start), .start_addr(start_addr), .start_len(start_len),
    .busy(busy), .done(done), .err(err),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_data_avail_cnt(fifo_data_avail_cnt),
    .axi(axi)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } w_t;

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          eb;       // burst index answered with SLVERR, -1 = none
    int          wm;       // 0 ready high, 1 toggling, 2 random
    int          exp_nb;
    int          exp_err;
    int          exp_awlen0;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side state shared between monitor, driver and stimulus.
  logic [DATA_WIDTH-1:0] fifo_q[$];
  logic [DATA_WIDTH-1:0] exp_data[$];
  aw_t aw_log[$];
  w_t  w_log[$];
  aw_t exp_aw[$];
  int  rd_cnt, rd_empty_viol, stab_viol, done_cnt, awv_seen;
  int  done_err, done_busy, cyc, last_b_cyc, done_cyc;
  int  b_idx, err_burst, w_mode;
  logic s_rd, s_wlast_hs, s_b_hs;
  logic aw_stall_p, w_stall_p, p_wlast;
  logic [31:0] p_awaddr;
  logic [7:0]  p_awlen;
  logic [DATA_WIDTH-1:0] p_wdata;

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fifo_update();
    fifo_empty          = (fifo_q.size() == 0);
    fifo_data_avail_cnt = FIFO_PTR'(fifo_q.size());
  endtask

  task automatic push_beat();
    logic [DATA_WIDTH-1:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    fifo_q.push_back(d);
    exp_data.push_back(d);
    fifo_update();
  endtask

  // Outputs are sampled on the falling edge; inputs only change 1ns after the
  // rising edge, so what is seen here is what the next rising edge commits.
  always @(negedge clk) begin
    cyc++;
    s_rd       = fifo_rd_en;
    s_wlast_hs = axi.m_axi_wvalid && axi.m_axi_wready && axi.m_axi_wlast;
    s_b_hs     = axi.m_axi_bvalid && axi.m_axi_bready;
    if (!reset_n) begin
      aw_stall_p = 1'b0;
      w_stall_p  = 1'b0;
    end else begin
      if (fifo_rd_en) rd_cnt++;
      if (fifo_rd_en && fifo_empty) rd_empty_viol++;
      if (axi.m_axi_awvalid) awv_seen++;
      if (aw_stall_p && !(axi.m_axi_awvalid && axi.m_axi_awaddr == p_awaddr &&
                          axi.m_axi_awlen == p_awlen)) stab_viol++;
      if (w_stall_p && !(axi.m_axi_wvalid && axi.m_axi_wdata == p_wdata &&
                         axi.m_axi_wlast == p_wlast)) stab_viol++;
      aw_stall_p = axi.m_axi_awvalid && !axi.m_axi_awready;
      w_stall_p  = axi.m_axi_wvalid && !axi.m_axi_wready;
      p_awaddr   = axi.m_axi_awaddr;
      p_awlen    = axi.m_axi_awlen;
      p_wdata    = axi.m_axi_wdata;
      p_wlast    = axi.m_axi_wlast;
      if (axi.m_axi_awvalid && axi.m_axi_awready)
        aw_log.push_back('{axi.m_axi_awaddr, axi.m_axi_awlen, axi.m_axi_awsize, axi.m_axi_awburst});
      if (axi.m_axi_wvalid && axi.m_axi_wready)
        w_log.push_back('{axi.m_axi_wdata, axi.m_axi_wlast});
      if (s_b_hs) last_b_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_err  = int'(err);
        done_busy = int'(busy);
        done_cyc  = cyc;
      end
    end
  end

  // FIFO read port and AXI slave responses.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      axi.m_axi_bvalid = 1'b0;
    end else begin
      if (s_rd && fifo_q.size() > 0) begin
        fifo_rd_data = fifo_q.pop_front();
        fifo_update();
      end
      if (s_b_hs) axi.m_axi_bvalid = 1'b0;
      if (s_wlast_hs) begin
        axi.m_axi_bvalid = 1'b1;
        axi.m_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        b_idx++;
      end
      case (w_mode)
        0:       begin axi.m_axi_wready = 1'b1; axi.m_axi_awready = 1'b1; end
        1:       begin axi.m_axi_wready = ~axi.m_axi_wready; axi.m_axi_awready = 1'b1; end
        default: begin
          axi.m_axi_wready  = 1'($urandom_range(0, 1));
          axi.m_axi_awready = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Reference: split [addr, addr+len*BYTES) into bursts of at most MAX_BURST
  // beats that stay inside one 4KB page; stop after the erroring burst.
  task automatic model(input logic [31:0] addr, input int len, input int eb);
    longint a;
    int rem, b, bnd, idx;
    exp_aw.delete();
    a = longint'(addr);
    rem = len;
    idx = 0;
    while (rem > 0) begin
      bnd = int'((4096 - (a % 4096)) / BYTES);
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > bnd) b = bnd;
      exp_aw.push_back('{a[31:0], 8'(b - 1), 3'd4, 2'd1});
      a = (a + longint'(b * BYTES)) % (64'd1 << 32);
      rem -= b;
      if (idx == eb) break;
      idx++;
    end
  endtask

  task automatic prep(input int eb, input int wm);
    aw_log.delete(); w_log.delete(); exp_data.delete(); fifo_q.delete();
    fifo_update();
    rd_cnt = 0; rd_empty_viol = 0; stab_viol = 0; done_cnt = 0; awv_seen = 0;
    done_err = -1; done_busy = -1; b_idx = 0; err_burst = eb; w_mode = wm;
  endtask

  task automatic kick(input logic [31:0] addr, input int len);
    @(posedge clk); #1;
    start = 1'b1; start_addr = addr; start_len = LEN_WIDTH'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (len > 0) check("busy after start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic verify(input string tag, input logic [31:0] addr, input int len, input int eb);
    int total, k, exp_err;
    model(addr, len, eb);
    check({tag, " bursts"}, aw_log.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++) begin
      check({tag, " awaddr"}, aw_log[i].addr, exp_aw[i].addr);
      check({tag, " awlen"}, aw_log[i].len, exp_aw[i].len);
      check({tag, " awsize/awburst"}, {aw_log[i].size, aw_log[i].burst}, {3'd4, 2'd1});
    end
    total = 0;
    foreach (exp_aw[i]) total += int'(exp_aw[i].len) + 1;
    check({tag, " w beats"}, w_log.size(), total);
    check({tag, " rd_en pulses"}, rd_cnt, total);
    k = 0;
    foreach (exp_aw[i]) begin
      for (int j = 0; j <= int'(exp_aw[i].len); j++) begin
        if (k < w_log.size()) begin
          check({tag, " wdata"}, w_log[k].data, exp_data[k]);
          check({tag, " wlast"}, w_log[k].last, (j == int'(exp_aw[i].len)));
        end
        k++;
      end
    end
    exp_err = (eb >= 0 && eb < exp_aw.size()) ? 1 : 0;
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " err"}, done_err, exp_err);
    check({tag, " busy at done"}, done_busy, 0);
    check({tag, " rd_en while empty"}, rd_empty_viol, 0);
    check({tag, " stall stability"}, stab_viol, 0);
    if (exp_aw.size() > 0) check({tag, " B to done"}, done_cyc - last_b_cyc, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, " awvalid"}, axi.m_axi_awvalid, 0);
    check({tag, " wvalid"}, axi.m_axi_wvalid, 0);
    check({tag, " wlast"}, axi.m_axi_wlast, 0);
    check({tag, " bready"}, axi.m_axi_bready, 0);
    check({tag, " awaddr"}, axi.m_axi_awaddr, 0);
    check({tag, " awlen"}, axi.m_axi_awlen, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{32'h0000_1000, 16, -1, 0, 1, 0, 15};
    vecs[1] = '{32'h0000_0000, 40, -1, 0, 3, 0, 15};
    vecs[2] = '{32'h0000_0FE0,  4, -1, 0, 2, 0,  1};
    vecs[3] = '{32'h0000_2000, 48,  0, 0, 1, 1, 15};
    vecs[4] = '{32'h0000_0F00, 20, -1, 1, 2, 0, 15};
    vecs[5] = '{32'h0000_3000,  0, -1, 0, 0, 0,  0};
    vecs[6] = '{32'h0000_0FF0,  3, -1, 2, 2, 0,  0};
    vecs[7] = '{32'h0000_5000, 40,  1, 2, 2, 1, 15};

    start = 1'b0; start_addr = '0; start_len = '0; fifo_rd_data = '0;
    axi.m_axi_awready = 1'b1; axi.m_axi_wready = 1'b1;
    axi.m_axi_bvalid = 1'b0; axi.m_axi_bresp = 2'b00;
    cyc = 0; last_b_cyc = 0; done_cyc = 0;
    prep(-1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      prep(vecs[i].eb, vecs[i].wm);
      for (int b = 0; b < vecs[i].len; b++) push_beat();
      kick(vecs[i].addr, vecs[i].len);
      wait_done(3000);
      check($sformatf("vec%0d burst count", i), aw_log.size(), vecs[i].exp_nb);
      check($sformatf("vec%0d err", i), err, vecs[i].exp_err);
      if (aw_log.size() > 0)
        check($sformatf("vec%0d first awlen", i), aw_log[0].len, vecs[i].exp_awlen0);
      verify($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].eb);
    end

    // Slow refill: only 3 beats available for 20 cycles, then the rest.
    prep(-1, 1);
    for (int b = 0; b < 3; b++) push_beat();
    kick(32'h0000_4000, 16);
    repeat (20) @(posedge clk);
    check("slow refill awvalid held off", awv_seen, 0);
    check("slow refill no reads", rd_cnt, 0);
    #1;
    for (int b = 0; b < 13; b++) push_beat();
    wait_done(3000);
    verify("slow refill", 32'h0000_4000, 16, -1);

    // Reset while the fifth W beat is on the bus.
    prep(-1, 0);
    for (int b = 0; b < 16; b++) push_beat();
    kick(32'h0000_6000, 16);
    n = 0;
    while (w_log.size() < 4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("beats before reset", w_log.size(), 4);
    reset_n = 1'b0;
    #1;
    check_idle("mid-burst reset");
    repeat (3) @(posedge clk);
    check("no done after reset", done_cnt, 0);
    #1;
    reset_n = 1'b1;
    prep(-1, 0);
    for (int b = 0; b < 2; b++) push_beat();
    kick(32'h0000_7000, 2);
    wait_done(3000);
    verify("after reset", 32'h0000_7000, 2, -1);

    // Randomised transfers, many landing near a 4KB boundary.
    for (int t = 0; t < 14; t++) begin
      logic [31:0] a;
      int l, e, m;
      a = 32'h0001_0000 + ($urandom_range(0, 511) << 4);
      l = $urandom_range(0, 45);
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      m = $urandom_range(0, 2);
      prep(e, m);
      for (int b = 0; b < l; b++) push_beat();
      kick(a, l);
      wait_done(3000);
      verify($sformatf("rand%0d", t), a, l, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
